seg_scan_ctrl: RTL and testbench
================================

Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for a bank of common-anode 7-segment digits. One shared hex-to-segment decoder is driven by NUM_DIGITS digit registers. The block owns those registers, a write port, the refresh prescaler and the scan state machine, and it drives one active-low digit select plus one active-low segment bus. It sits between counter/datapath logic, which writes the digit values, and the board pins.

Parameters:
NUM_DIGITS, 8, number of digits scanned (2..16)
DIV, 50000, clk cycles each digit stays selected (>=2)
AW, $clog2(NUM_DIGITS), digit index width (derived, not overridden)
CW, $clog2(DIV), prescaler width (derived)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
en  in  1  scan enable; 0 = display dark
wr_en  in  1  write strobe for one digit register
wr_addr  in  AW  digit index to write
wr_data  in  4  hex value 0..F
wr_dp  in  1  decimal point lit for that digit
wr_blank  in  1  digit forced dark
seg_out  out  8  active-low segments; bit0=a..bit6=g, bit7=dp
an_out  out  NUM_DIGITS  active-low digit select, one-cold
scan_idx  out  AW  index currently driven

Behaviour:
- Interface: one clock (clk); synchronous active-high reset (rst).
- Reset values:
  - Digit registers: data=0, dp=0, blank=1.
  - cnt=0, scan_idx=0, state=IDLE.
  - seg_out=8'hFF, an_out=all ones.
- Writes:
  - wr_en updates register wr_addr at the clock edge. Writes are accepted in any state.
  - Out-of-range wr_addr (>=NUM_DIGITS) is ignored.
- FSM states IDLE and SCAN:
  - IDLE->SCAN on en=1.
  - SCAN->IDLE on en=0. cnt and scan_idx clear to 0; seg_out=8'hFF and an_out=all ones on the next edge.
- Prescaler (in SCAN): cnt increments each cycle. At cnt==DIV-1, cnt returns to 0 and scan_idx advances, wrapping NUM_DIGITS-1 -> 0.
- Output latency: outputs are registered, so seg_out/an_out at edge t+1 reflect scan_idx and register contents at edge t. Total latency from entering SCAN is 1 cycle.
- Output values (SCAN):
  - an_out = ~(1<<scan_idx).
  - seg_out = {~dp, hex7(data)}, or 8'hFF when blank=1.
- hex7 (active-low a..g): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E.
- Simultaneous write and advance: both take effect. A write to the digit about to be selected appears with the new value.
- rst mid-scan overrides everything, including a concurrent wr_en.
- an_out never has more than one bit low; there is no glitch cycle on advance.

Optional Feature:
SEG_LZ_SUPPRESS_EN
- Defined: a digit is displayed as 8'hFF when all of these hold:
  - Its value is 0, dp=0, and index>0.
  - Every higher-index digit is either blank or itself suppressed.
  - Digit 0 is never suppressed.
  - Evaluated combinationally from current registers; same 1-cycle output latency.
- Undefined: zeros are always shown; no suppression logic is built.

Decomposition:
- Shared header seg_defs.vh: SEG_OFF (8'hFF), the 16 hex7 patterns as named constants, and segment bit-position constants.
- Sub-module hex7seg (4-bit in, 7-bit active-low out), instantiated once as the shared decoder.
- FSM, prescaler, register file and optional suppression logic stay in seg_scan_ctrl.

Test Plan:
- Reset (DIV=4, NUM_DIGITS=4): hold rst 3 cycles with en=1 -> seg_out=FF, an_out=4'b1111, scan_idx=0 throughout; one cycle after release an_out=4'b1110, seg_out=FF (blank).
- Write all four digits, then en=1: digits 0..3 = 0,1,8,A, dp on digit 2 -> per 4-cycle slot seg_out=C0,F9,00,88 with an_out=1110,1101,1011,0111; then wraps to 1110.
- Drop en mid-slot on digit 2 -> next edge seg_out=FF, an_out=1111; re-enable -> digit 0 shown first after 1 cycle.
- Write digit 1 =F on the cycle cnt==3 while idx=0 -> next slot shows 8E on an_out=1101; write wr_addr=5 -> no register changes.
- SEG_LZ_SUPPRESS_EN with digits 3..0 = 0,0,4,0 -> digits 3,2 show FF, digit 1 shows 99, digit 0 shows C0. Without the macro, digits 3,2 show C0.
- Assert rst during SCAN with a concurrent wr_en -> write is discarded, all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/seg_scan_ctrl_pkg.sv
// Shared types and constants for the 7-segment scan controller.
// Latency: n/a (package).
// Backpressure: n/a.
package seg_scan_ctrl_pkg;

  `include "seg_defs.vh"

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

endpackage

// File: rtl/seg_defs.vh
// Shared 7-segment definitions: blank pattern, hex glyphs, segment bit positions.
// Latency: n/a (constants only).
// Backpressure: n/a.
// Glyphs are active-low, bit0=a .. bit6=g; bit7 of the full bus is the dp.
`ifndef SEG_DEFS_VH
`define SEG_DEFS_VH

localparam logic [7:0] SEG_OFF = 8'hFF;

localparam int SEG_BIT_A  = 0;
localparam int SEG_BIT_G  = 6;
localparam int SEG_BIT_DP = 7;

localparam logic [6:0] HEX7_0 = 7'h40;
localparam logic [6:0] HEX7_1 = 7'h79;
localparam logic [6:0] HEX7_2 = 7'h24;
localparam logic [6:0] HEX7_3 = 7'h30;
localparam logic [6:0] HEX7_4 = 7'h19;
localparam logic [6:0] HEX7_5 = 7'h12;
localparam logic [6:0] HEX7_6 = 7'h02;
localparam logic [6:0] HEX7_7 = 7'h78;
localparam logic [6:0] HEX7_8 = 7'h00;
localparam logic [6:0] HEX7_9 = 7'h10;
localparam logic [6:0] HEX7_A = 7'h08;
localparam logic [6:0] HEX7_B = 7'h03;
localparam logic [6:0] HEX7_C = 7'h46;
localparam logic [6:0] HEX7_D = 7'h21;
localparam logic [6:0] HEX7_E = 7'h06;
localparam logic [6:0] HEX7_F = 7'h0E;

`endif

// File: rtl/seg_scan_ctrl_hex7seg.sv
// Shared hex-to-7-segment decoder (active-low a..g).
// Latency: combinational.
// Backpressure: none.
// Ports: hex (4-bit value), seg (7-bit active-low pattern, bit0=a).
module hex7seg
  import seg_scan_ctrl_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = HEX7_8;
    case (hex)
      4'h0: seg = HEX7_0;
      4'h1: seg = HEX7_1;
      4'h2: seg = HEX7_2;
      4'h3: seg = HEX7_3;
      4'h4: seg = HEX7_4;
      4'h5: seg = HEX7_5;
      4'h6: seg = HEX7_6;
      4'h7: seg = HEX7_7;
      4'h8: seg = HEX7_8;
      4'h9: seg = HEX7_9;
      4'hA: seg = HEX7_A;
      4'hB: seg = HEX7_B;
      4'hC: seg = HEX7_C;
      4'hD: seg = HEX7_D;
      4'hE: seg = HEX7_E;
      4'hF: seg = HEX7_F;
      default: seg = HEX7_8;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for NUM_DIGITS common-anode 7-seg digits.
// Latency: seg_out/an_out registered, 1 cycle after scan_idx/register contents.
// Backpressure: none; writes accepted every cycle, out-of-range addresses dropped.
// Ports: clk, rst (sync, active-high), en (scan enable), wr_en/wr_addr/wr_data/
//   wr_dp/wr_blank (digit register write), seg_out (active-low, bit7=dp),
//   an_out (active-low one-cold select), scan_idx (digit currently addressed).
// Optional: define SEG_LZ_SUPPRESS_EN to blank leading zeros.
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter  int NUM_DIGITS = 8,
  parameter  int DIV        = 50000,
  localparam int AW         = $clog2(NUM_DIGITS),
  localparam int CW         = $clog2(DIV)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [3:0]            wr_data,
  input  logic                  wr_dp,
  input  logic                  wr_blank,
  output logic [7:0]            seg_out,
  output logic [NUM_DIGITS-1:0] an_out,
  output logic [AW-1:0]         scan_idx
);

  // Digit register file
  logic [3:0]            data_q [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] dp_q;
  logic [NUM_DIGITS-1:0] blank_q;

  // Widened compare so non-power-of-two digit counts reject the unused codes.
  logic wr_hit;
  assign wr_hit = wr_en && ({1'b0, wr_addr} < (AW+1)'(NUM_DIGITS));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) data_q[i] <= 4'h0;
      dp_q    <= '0;
      blank_q <= '1;
    end else if (wr_hit) begin
      data_q[wr_addr]  <= wr_data;
      dp_q[wr_addr]    <= wr_dp;
      blank_q[wr_addr] <= wr_blank;
    end
  end

  // FSM: state register / next state / output decode
  state_t state_q, state_d;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (en)  state_d = ST_SCAN;
      ST_SCAN: if (!en) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Prescaler and digit index. The count runs on every cycle whose next
  // state is SCAN, so the first slot after enabling lasts DIV cycles like
  // every other slot.
  logic [CW-1:0] cnt_q;
  logic [AW-1:0] idx_q;

  always_ff @(posedge clk) begin
    if (rst || state_d == ST_IDLE) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else if (cnt_q == CW'(DIV - 1)) begin
      cnt_q <= '0;
      idx_q <= (idx_q == AW'(NUM_DIGITS - 1)) ? '0 : idx_q + AW'(1);
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign scan_idx = idx_q;

  // Single shared decoder, fed by the currently addressed digit.
  logic [6:0] hex_seg;

  hex7seg u_hex7seg (
    .hex (data_q[idx_q]),
    .seg (hex_seg)
  );

  logic digit_dark;

`ifdef SEG_LZ_SUPPRESS_EN
  // Walk down from the top digit: a zero without dp is suppressed only while
  // everything above it is already dark. Digit 0 is never suppressed.
  logic [NUM_DIGITS-1:0] supp;

  always_comb begin
    logic hi_dark;
    hi_dark = 1'b1;
    supp    = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      supp[i] = hi_dark && (data_q[i] == 4'h0) && !dp_q[i];
      hi_dark = hi_dark && (blank_q[i] || supp[i]);
    end
  end

  assign digit_dark = blank_q[idx_q] | supp[idx_q];
`else
  assign digit_dark = blank_q[idx_q];
`endif

  logic [7:0]            seg_d;
  logic [NUM_DIGITS-1:0] an_d;

  // Outputs follow the next state so dropping en blanks on the same edge.
  always_comb begin
    seg_d = SEG_OFF;
    an_d  = '1;
    if (state_d == ST_SCAN) begin
      an_d = ~(NUM_DIGITS'(1) << idx_q);
      if (!digit_dark) begin
        seg_d[SEG_BIT_DP]          = ~dp_q[idx_q];
        seg_d[SEG_BIT_G:SEG_BIT_A] = hex_seg;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_out <= SEG_OFF;
      an_out  <= '1;
    end else begin
      seg_out <= seg_d;
      an_out  <= an_d;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed self-checking bench for seg_scan_ctrl (4-digit/DIV=4 and 6-digit/DIV=2).
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_seg_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, wr_en, wr_dp, wr_blank;
  logic [1:0] wr_addr;
  logic [3:0] wr_data;
  logic [7:0] seg_out;
  logic [3:0] an_out;
  logic [1:0] scan_idx;

  logic       en6, wr_en6, wr_dp6, wr_blank6;
  logic [2:0] wr_addr6;
  logic [3:0] wr_data6;
  logic [7:0] seg6;
  logic [5:0] an6;
  logic [2:0] idx6;

  seg_scan_ctrl #(.NUM_DIGITS(4), .DIV(4)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_dp    (wr_dp),
    .wr_blank (wr_blank),
    .seg_out  (seg_out),
    .an_out   (an_out),
    .scan_idx (scan_idx)
  );

  seg_scan_ctrl #(.NUM_DIGITS(6), .DIV(2)) u_dut6 (
    .clk      (clk),
    .rst      (rst),
    .en       (en6),
    .wr_en    (wr_en6),
    .wr_addr  (wr_addr6),
    .wr_data  (wr_data6),
    .wr_dp    (wr_dp6),
    .wr_blank (wr_blank6),
    .seg_out  (seg6),
    .an_out   (an6),
    .scan_idx (idx6)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr4(input logic [1:0] a, input logic [3:0] d, input logic dp, input logic bl);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_dp = dp; wr_blank = bl;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wr6(input logic [2:0] a, input logic [3:0] d, input logic dp, input logic bl);
    wr_en6 = 1'b1; wr_addr6 = a; wr_data6 = d; wr_dp6 = dp; wr_blank6 = bl;
    tick();
    wr_en6 = 1'b0;
  endtask

`ifdef SEG_LZ_SUPPRESS_EN
  localparam logic [7:0] LZ_HI = 8'hFF;
`else
  localparam logic [7:0] LZ_HI = 8'hC0;
`endif

  // Hand-computed glyphs: 0->C0, 1->F9, 8+dp->00, A->88; 0,4,0,0 for the zero test.
  logic [7:0] exp_scan [4] = '{8'hC0, 8'hF9, 8'h00, 8'h88};
  logic [7:0] exp_lz   [4] = '{8'hC0, 8'h99, LZ_HI, LZ_HI};
  logic [3:0] an_tab   [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; en = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_dp = 1'b0; wr_blank = 1'b0;
    en6 = 1'b0; wr_en6 = 1'b0; wr_addr6 = '0; wr_data6 = '0; wr_dp6 = 1'b0; wr_blank6 = 1'b0;

    // Reset held with en=1
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_seg", seg_out, 8'hFF);
      chk("rst_an", an_out, 4'hF);
      chk("rst_idx", scan_idx, 2'd0);
    end
    rst = 1'b0;
    tick();
    chk("rel_an", an_out, 4'b1110);
    chk("rel_seg", seg_out, 8'hFF);

    // Load digits while idle
    en = 1'b0;
    tick();
    chk("idle_seg", seg_out, 8'hFF);
    chk("idle_an", an_out, 4'hF);
    wr4(2'd0, 4'h0, 1'b0, 1'b0);
    wr4(2'd1, 4'h1, 1'b0, 1'b0);
    wr4(2'd2, 4'h8, 1'b1, 1'b0);
    wr4(2'd3, 4'hA, 1'b0, 1'b0);

    // Full scan with wrap back to digit 0
    en = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk($sformatf("scan_seg%0d", k), seg_out, exp_scan[(k / 4) % 4]);
      chk($sformatf("scan_an%0d", k), an_out, an_tab[(k / 4) % 4]);
    end

    // Into the middle of digit 2's slot, then drop en
    repeat (6) tick();
    chk("mid_seg", seg_out, 8'h00);
    chk("mid_an", an_out, 4'b1011);
    en = 1'b0;
    tick();
    chk("drop_seg", seg_out, 8'hFF);
    chk("drop_an", an_out, 4'hF);
    chk("drop_idx", scan_idx, 2'd0);
    en = 1'b1;
    tick();
    chk("reen_seg", seg_out, 8'hC0);
    chk("reen_an", an_out, 4'b1110);
    chk("reen_idx", scan_idx, 2'd0);

    // Write digit 1 on the advance cycle (cnt==3, idx=0)
    tick();
    tick();
    wr_en = 1'b1; wr_addr = 2'd1; wr_data = 4'hF; wr_dp = 1'b0; wr_blank = 1'b0;
    tick();
    wr_en = 1'b0;
    chk("wadv_seg0", seg_out, 8'hC0);
    chk("wadv_an0", an_out, 4'b1110);
    chk("wadv_idx", scan_idx, 2'd1);
    tick();
    chk("wadv_seg1", seg_out, 8'h8E);
    chk("wadv_an1", an_out, 4'b1101);

    // Leading-zero pattern 3..0 = 0,0,4,0
    en = 1'b0;
    tick();
    wr4(2'd3, 4'h0, 1'b0, 1'b0);
    wr4(2'd2, 4'h0, 1'b0, 1'b0);
    wr4(2'd1, 4'h4, 1'b0, 1'b0);
    wr4(2'd0, 4'h0, 1'b0, 1'b0);
    en = 1'b1;
    for (int k = 0; k < 16; k++) begin
      tick();
      chk($sformatf("lz_seg%0d", k), seg_out, exp_lz[k / 4]);
      chk($sformatf("lz_an%0d", k), an_out, an_tab[k / 4]);
    end

    // Six-digit instance: out-of-range writes must leave all registers blank
    wr6(3'd7, 4'h8, 1'b0, 1'b0);
    wr6(3'd6, 4'h8, 1'b0, 1'b0);
    wr6(3'd5, 4'h3, 1'b0, 1'b0);
    en6 = 1'b1;
    for (int k = 0; k < 14; k++) begin
      int d;
      logic [5:0] a6;
      d  = (k / 2) % 6;
      a6 = 6'h3F ^ (6'h01 << d);
      tick();
      chk($sformatf("d6_seg%0d", k), seg6, (d == 5) ? 8'hB0 : 8'hFF);
      chk($sformatf("d6_an%0d", k), an6, a6);
    end
    en6 = 1'b0;

    // Reset in the middle of scanning with a concurrent write
    tick();
    tick();
    rst = 1'b1;
    wr_en = 1'b1; wr_addr = 2'd3; wr_data = 4'h5; wr_dp = 1'b1; wr_blank = 1'b0;
    tick();
    rst = 1'b0;
    wr_en = 1'b0;
    chk("mrst_seg", seg_out, 8'hFF);
    chk("mrst_an", an_out, 4'hF);
    chk("mrst_idx", scan_idx, 2'd0);
    for (int k = 0; k < 16; k++) begin
      tick();
      chk($sformatf("post_seg%0d", k), seg_out, 8'hFF);
      chk($sformatf("post_an%0d", k), an_out, an_tab[k / 4]);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
